// File: rtl/result_frame_tx_pkg.sv
// rtl/result_frame_tx_pkg.sv - shared state encoding, frame constants and helpers for result_frame_tx
package result_frame_tx_pkg;

    // Frame sequencer states. The handshake sub-module reuses ISSUE/WAIT_HI/WAIT_LO
    // for its own per-byte phase so both views share one encoding.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        ISSUE   = 3'd2,
        WAIT_HI = 3'd3,
        WAIT_LO = 3'd4,
        ADVANCE = 3'd5,
        FIN     = 3'd6
    } state_t;

    // Which part of the frame the current byte belongs to.
    typedef enum logic [1:0] {
        FIELD_HEADER = 2'd0,
        FIELD_SIZE   = 2'd1,
        FIELD_ELEM   = 2'd2,
        FIELD_CHK    = 2'd3
    } field_t;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

    // Sizes above the synthesized maximum are sent as the maximum.
    function automatic logic [3:0] clamp_size(input logic [3:0] n, input logic [3:0] max_n);
        return (n > max_n) ? max_n : n;
    endfunction

endpackage

// File: rtl/result_frame_tx_byte_handshake.sv
// rtl/result_frame_tx_byte_handshake.sv - one-byte start/busy handshake towards uart_tx
// Ports:
//   bclk, rst          clock, synchronous active-high reset
//   go                 level, high while the parent wants byte_in sent
//   byte_in            byte to send
//   tx_busy            from uart_tx
//   tx_data, tx_start  to uart_tx
//   byte_done          one-cycle pulse once uart_tx has finished the byte
module tx_byte_handshake
    import result_frame_tx_pkg::*;
(
    input  logic       bclk,
    input  logic       rst,
    input  logic       go,
    input  logic [7:0] byte_in,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       byte_done
);

    state_t     phase;
    state_t     phase_next;
    logic [7:0] data_q;

    // Dropping go (parent left its ISSUE state, or reset) re-arms the phase.
    always_ff @(posedge bclk) begin
        if (rst || !go) begin
            phase <= ISSUE;
        end else begin
            phase <= phase_next;
        end
    end

    always_ff @(posedge bclk) begin
        if (rst) begin
            data_q <= 8'h00;
        end else if (tx_start) begin
            data_q <= byte_in;
        end
    end

    always_comb begin
        phase_next = phase;
        tx_start   = 1'b0;
        byte_done  = 1'b0;
        if (go) begin
            case (phase)
                ISSUE: begin
                    if (!tx_busy) begin
                        tx_start   = 1'b1;
                        phase_next = WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (tx_busy) begin
                        phase_next = WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (!tx_busy) begin
                        byte_done  = 1'b1;
                        phase_next = ISSUE;
                    end
                end
                default: phase_next = ISSUE;
            endcase
        end
    end

    // The byte must already be on tx_data in the tx_start cycle, so the
    // pending byte is forwarded while issuing and held afterwards.
    assign tx_data = (go && phase == ISSUE) ? byte_in : data_q;

endmodule

// File: rtl/result_frame_tx.sv
// rtl/result_frame_tx.sv - serializes a captured result matrix as a checksummed byte frame into uart_tx
// Ports:
//   bclk, rst      clock, synchronous active-high reset
//   start          one-cycle frame request, accepted only when idle
//   matrix_size    dimension N sampled with start (clamped to MAX_SIZE)
//   result         flat matrix, element (r,c) at [(r*MAX_SIZE+c)*ELEM_WIDTH +: ELEM_WIDTH]
//   tx_busy        from uart_tx
//   tx_data        byte to uart_tx
//   tx_start       one-cycle transmit request to uart_tx
//   busy           frame in progress
//   done           one-cycle pulse after the checksum byte completes
// Frame: HEADER, N, N*N elements row-major LSB byte first, CHK = (N + element bytes) mod 256.
module result_frame_tx
    import result_frame_tx_pkg::*;
#(
    parameter int         MAX_SIZE   = 3,
    parameter int         ELEM_WIDTH = 16,
    parameter logic [7:0] HEADER     = HEADER_DEFAULT
) (
    input  logic                                  bclk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [3:0]                            matrix_size,
    input  logic [MAX_SIZE*MAX_SIZE*ELEM_WIDTH-1:0] result,
    input  logic                                  tx_busy,
    output logic [7:0]                            tx_data,
    output logic                                  tx_start,
    output logic                                  busy,
    output logic                                  done
);

    localparam int RES_W = MAX_SIZE * MAX_SIZE * ELEM_WIDTH;
    localparam int BYTES = ELEM_WIDTH / 8;
    localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;

    state_t            state;
    state_t            state_next;
    field_t            field;
    logic [RES_W-1:0]  result_q;
    logic [3:0]        ne_q;
    logic [BC_W-1:0]   byte_cnt;
    logic [3:0]        col;
    logic [3:0]        row;
    logic [7:0]        chk;
    logic [7:0]        cur_byte;
    logic              byte_done;
    int                byte_idx;

    tx_byte_handshake u_handshake (
        .bclk      (bclk),
        .rst       (rst),
        .go        (state == ISSUE),
        .byte_in   (cur_byte),
        .tx_busy   (tx_busy),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .byte_done (byte_done)
    );

    always_ff @(posedge bclk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ISSUE covers the whole per-byte handshake; the sub-module walks the
    // WAIT_HI/WAIT_LO phases and reports completion through byte_done.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    state_next = ISSUE;
            ISSUE:   if (byte_done) state_next = ADVANCE;
            ADVANCE: state_next = (field == FIELD_CHK) ? FIN : ISSUE;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE) && (state != FIN);
    assign done = (state == FIN);

    // Byte selected by the field and counters; shift-based select keeps the
    // index arithmetic free of part-select width constraints.
    always_comb begin
        cur_byte = 8'h00;
        byte_idx = 0;
        case (field)
            FIELD_HEADER: cur_byte = HEADER;
            FIELD_SIZE:   cur_byte = {4'h0, ne_q};
            FIELD_ELEM: begin
                byte_idx = (int'(row) * MAX_SIZE + int'(col)) * BYTES + int'(byte_cnt);
                cur_byte = 8'(result_q >> (byte_idx * 8));
            end
            FIELD_CHK:    cur_byte = chk;
            default:      cur_byte = 8'h00;
        endcase
    end

    always_ff @(posedge bclk) begin
        if (rst) begin
            result_q <= '0;
            ne_q     <= 4'd0;
            field    <= FIELD_HEADER;
            byte_cnt <= '0;
            col      <= 4'd0;
            row      <= 4'd0;
            chk      <= 8'h00;
        end else begin
            // Operands are taken on the accepting edge so later changes on
            // result cannot leak into the frame.
            if (state == IDLE && start) begin
                result_q <= result;
                ne_q     <= clamp_size(matrix_size, 4'(MAX_SIZE));
            end
            if (state == LOAD) begin
                field    <= FIELD_HEADER;
                byte_cnt <= '0;
                col      <= 4'd0;
                row      <= 4'd0;
                chk      <= 8'h00;
            end
            if (state == ADVANCE) begin
                case (field)
                    FIELD_HEADER: field <= FIELD_SIZE;
                    FIELD_SIZE: begin
                        chk   <= chk + {4'h0, ne_q};
                        field <= (ne_q == 4'd0) ? FIELD_CHK : FIELD_ELEM;
                    end
                    FIELD_ELEM: begin
                        chk <= chk + cur_byte;
                        if (byte_cnt == BC_W'(BYTES - 1)) begin
                            byte_cnt <= '0;
                            if (col == ne_q - 4'd1) begin
                                col <= 4'd0;
                                row <= row + 4'd1;
                                // Element section ends as row reaches Ne.
                                if (row == ne_q - 4'd1) begin
                                    field <= FIELD_CHK;
                                end
                            end else begin
                                col <= col + 4'd1;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                    default: field <= FIELD_CHK;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_result_frame_tx.sv
// tb/tb_result_frame_tx.sv - directed self-checking bench for result_frame_tx
module tb_result_frame_tx;

    localparam int RES_W = 3 * 3 * 16;

    logic             bclk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [3:0]       matrix_size = 4'd0;
    logic [RES_W-1:0] result = '0;
    logic             tx_busy;
    logic [7:0]       tx_data;
    logic             tx_start;
    logic             busy;
    logic             done;

    int checks = 0;
    int failures = 0;

    logic       force_busy = 1'b0;
    int         ucnt = 0;
    logic [7:0] cap[$];
    int         done_cnt = 0;
    int         viol = 0;
    logic       prev_start = 1'b0;

    logic [RES_W-1:0] r2;
    logic [RES_W-1:0] r3;
    logic [7:0]       exp2[$];
    logic [7:0]       exp3[$];
    logic [7:0]       exp0[$];

    result_frame_tx dut (
        .bclk        (bclk),
        .rst         (rst),
        .start       (start),
        .matrix_size (matrix_size),
        .result      (result),
        .tx_busy     (tx_busy),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .busy        (busy),
        .done        (done)
    );

    always #5 bclk = ~bclk;

    // uart_tx model: busy from the cycle after tx_start for 10 cycles.
    assign tx_busy = (ucnt != 0) || force_busy;

    always @(posedge bclk) begin
        if (tx_start && ucnt == 0) ucnt <= 10;
        else if (ucnt != 0)        ucnt <= ucnt - 1;
    end

    // Byte capture and protocol monitor.
    always @(posedge bclk) begin
        if (tx_start && tx_busy)    viol = viol + 1;
        if (tx_start && prev_start) viol = viol + 1;
        if (tx_start)               cap.push_back(tx_data);
        if (done)                   done_cnt = done_cnt + 1;
        prev_start = tx_start;
    end

    task automatic pulse_start(input logic [3:0] n, input logic [RES_W-1:0] r);
        @(negedge bclk);
        start = 1'b1;
        matrix_size = n;
        result = r;
        @(negedge bclk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, output bit to);
        int k = 0;
        while (done_cnt == d0 && k < 3000) begin
            @(negedge bclk);
            k++;
        end
        to = (done_cnt == d0);
        repeat (3) @(negedge bclk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge bclk);
        checks++;
        if (tx_data !== 8'h00 || tx_start !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset: tx_data=%h tx_start=%b busy=%b done=%b required 00 0 0 0",
                     tx_data, tx_start, busy, done);
        end
        rst = 1'b0;
        @(negedge bclk);
    endtask

    task automatic test_frame_2x2;
        int d0;
        int v0;
        bit to;
        cap.delete();
        d0 = done_cnt;
        v0 = viol;
        @(negedge bclk);
        start = 1'b1;
        matrix_size = 4'd2;
        result = r2;
        @(negedge bclk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || tx_start !== 1'b0) begin
            failures++;
            $display("FAIL 2x2_load_cycle: busy=%b tx_start=%b required 1 0", busy, tx_start);
        end
        @(negedge bclk);
        checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'hA5) begin
            failures++;
            $display("FAIL 2x2_header_latency: tx_start=%b tx_data=%h required 1 a5", tx_start, tx_data);
        end
        wait_done(d0, to);
        checks++;
        if (to) begin
            failures++;
            $display("FAIL 2x2_timeout: no done pulse within bound");
        end
        checks++;
        if (cap.size() !== exp2.size()) begin
            failures++;
            $display("FAIL 2x2_len: got %0d bytes required %0d", cap.size(), exp2.size());
        end
        for (int i = 0; i < exp2.size() && i < cap.size(); i++) begin
            checks++;
            if (cap[i] !== exp2[i]) begin
                failures++;
                $display("FAIL 2x2_byte%0d: got %h required %h", i, cap[i], exp2[i]);
            end
        end
        checks++;
        if (done_cnt - d0 !== 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL 2x2_done: pulses=%0d busy=%b required 1 0", done_cnt - d0, busy);
        end
        checks++;
        if (viol !== v0) begin
            failures++;
            $display("FAIL 2x2_protocol: violations=%0d required 0", viol - v0);
        end
    endtask

    task automatic test_full_3x3;
        int d0;
        bit to;
        cap.delete();
        d0 = done_cnt;
        pulse_start(4'd3, r3);
        wait_done(d0, to);
        checks++;
        if (to || cap.size() !== exp3.size()) begin
            failures++;
            $display("FAIL 3x3_len: timeout=%b got %0d bytes required %0d", to, cap.size(), exp3.size());
        end
        for (int i = 0; i < exp3.size() && i < cap.size(); i++) begin
            checks++;
            if (cap[i] !== exp3[i]) begin
                failures++;
                $display("FAIL 3x3_byte%0d: got %h required %h", i, cap[i], exp3[i]);
            end
        end
    endtask

    task automatic test_size_edges;
        int d0;
        bit to;
        cap.delete();
        d0 = done_cnt;
        pulse_start(4'd0, r3);
        wait_done(d0, to);
        checks++;
        if (to || cap.size() !== 3) begin
            failures++;
            $display("FAIL n0_len: timeout=%b got %0d bytes required 3", to, cap.size());
        end
        for (int i = 0; i < 3 && i < cap.size(); i++) begin
            checks++;
            if (cap[i] !== exp0[i]) begin
                failures++;
                $display("FAIL n0_byte%0d: got %h required %h", i, cap[i], exp0[i]);
            end
        end
        cap.delete();
        d0 = done_cnt;
        pulse_start(4'd7, r3);
        wait_done(d0, to);
        checks++;
        if (to || cap.size() !== exp3.size()) begin
            failures++;
            $display("FAIL n7_len: timeout=%b got %0d bytes required %0d", to, cap.size(), exp3.size());
        end
        for (int i = 0; i < exp3.size() && i < cap.size(); i++) begin
            checks++;
            if (cap[i] !== exp3[i]) begin
                failures++;
                $display("FAIL n7_byte%0d: got %h required %h", i, cap[i], exp3[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        int d0;
        int v0;
        int k;
        bit to;
        cap.delete();
        d0 = done_cnt;
        v0 = viol;
        @(negedge bclk);
        force_busy = 1'b1;
        pulse_start(4'd2, r2);
        repeat (50) @(negedge bclk);
        checks++;
        if (cap.size() !== 0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL bp_hold: bytes=%0d busy=%b required 0 1", cap.size(), busy);
        end
        force_busy = 1'b0;
        k = 0;
        while (cap.size() < 3 && k < 500) begin
            @(negedge bclk);
            k++;
        end
        pulse_start(4'd3, r3);
        wait_done(d0, to);
        checks++;
        if (to || cap.size() !== exp2.size()) begin
            failures++;
            $display("FAIL bp_len: timeout=%b got %0d bytes required %0d", to, cap.size(), exp2.size());
        end
        for (int i = 0; i < exp2.size() && i < cap.size(); i++) begin
            checks++;
            if (cap[i] !== exp2[i]) begin
                failures++;
                $display("FAIL bp_byte%0d: got %h required %h", i, cap[i], exp2[i]);
            end
        end
        checks++;
        if (done_cnt - d0 !== 1 || viol !== v0) begin
            failures++;
            $display("FAIL bp_protocol: done pulses=%0d violations=%0d required 1 0", done_cnt - d0, viol - v0);
        end
    endtask

    task automatic test_reset_mid_frame;
        int d0;
        int k;
        bit to;
        cap.delete();
        pulse_start(4'd2, r2);
        k = 0;
        while (cap.size() < 4 && k < 500) begin
            @(negedge bclk);
            k++;
        end
        checks++;
        if (cap.size() !== 4) begin
            failures++;
            $display("FAIL rst_reach4: got %0d bytes required 4", cap.size());
        end
        rst = 1'b1;
        @(negedge bclk);
        checks++;
        if (tx_start !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || tx_data !== 8'h00) begin
            failures++;
            $display("FAIL rst_mid: tx_start=%b busy=%b done=%b tx_data=%h required 0 0 0 00",
                     tx_start, busy, done, tx_data);
        end
        rst = 1'b0;
        d0 = done_cnt;
        repeat (40) @(negedge bclk);
        checks++;
        if (cap.size() !== 4 || done_cnt !== d0) begin
            failures++;
            $display("FAIL rst_quiet: bytes=%0d done pulses=%0d required 4 0", cap.size(), done_cnt - d0);
        end
        cap.delete();
        pulse_start(4'd3, r3);
        wait_done(d0, to);
        checks++;
        if (to || cap.size() !== exp3.size()) begin
            failures++;
            $display("FAIL rst_fresh_len: timeout=%b got %0d bytes required %0d", to, cap.size(), exp3.size());
        end
        for (int i = 0; i < exp3.size() && i < cap.size(); i++) begin
            checks++;
            if (cap[i] !== exp3[i]) begin
                failures++;
                $display("FAIL rst_fresh_byte%0d: got %h required %h", i, cap[i], exp3[i]);
            end
        end
    endtask

    task automatic test_operand_capture;
        int d0;
        bit to;
        cap.delete();
        d0 = done_cnt;
        @(negedge bclk);
        start = 1'b1;
        matrix_size = 4'd2;
        result = r2;
        @(negedge bclk);
        start = 1'b0;
        result = '1;
        matrix_size = 4'd3;
        wait_done(d0, to);
        checks++;
        if (to || cap.size() !== exp2.size()) begin
            failures++;
            $display("FAIL cap_len: timeout=%b got %0d bytes required %0d", to, cap.size(), exp2.size());
        end
        for (int i = 0; i < exp2.size() && i < cap.size(); i++) begin
            checks++;
            if (cap[i] !== exp2[i]) begin
                failures++;
                $display("FAIL cap_byte%0d: got %h required %h", i, cap[i], exp2[i]);
            end
        end
        result = '0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        r2 = '0;
        r2[0*16 +: 16] = 16'd1;
        r2[1*16 +: 16] = 16'd2;
        r2[3*16 +: 16] = 16'd3;
        r2[4*16 +: 16] = 16'd4;
        for (int i = 0; i < 9; i++) r3[i*16 +: 16] = 16'h1234;
        exp2 = '{8'hA5, 8'h02, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00, 8'h0C};
        exp0 = '{8'hA5, 8'h00, 8'h00};
        exp3 = '{8'hA5, 8'h03};
        for (int i = 0; i < 9; i++) begin
            exp3.push_back(8'h34);
            exp3.push_back(8'h12);
        end
        exp3.push_back(8'h79);

        test_reset();
        test_frame_2x2();
        test_full_3x3();
        test_size_edges();
        test_backpressure();
        test_reset_mid_frame();
        test_operand_capture();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
